// File: rtl/hd_dma_controller_if.sv
// Bundles the CPU request handshake with the HardDisk and main-memory ports
// driven by hd_dma_controller.
interface hd_dma_controller_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int HD_ADDR_WIDTH  = 13,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int TRACK_WIDTH    = 4,
  parameter int SECTOR_WIDTH   = 10,
  parameter int LEN_WIDTH      = 10
);
  logic                      start;
  logic                      dir;
  logic [TRACK_WIDTH-1:0]    track;
  logic [SECTOR_WIDTH-1:0]   sector;
  logic [MEM_ADDR_WIDTH-1:0] mem_base;
  logic [LEN_WIDTH-1:0]      length;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic [HD_ADDR_WIDTH-1:0]  hd_addr_r;
  logic [HD_ADDR_WIDTH-1:0]  hd_addr_w;
  logic                      hd_we;
  logic [DATA_WIDTH-1:0]     hd_data;
  logic [DATA_WIDTH-1:0]     hd_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport master (
    input  start, dir, track, sector, mem_base, length, hd_q, mem_rdata,
    output busy, done, error, hd_addr_r, hd_addr_w, hd_we, hd_data,
           mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output start, dir, track, sector, mem_base, length, hd_q, mem_rdata,
    input  busy, done, error, hd_addr_r, hd_addr_w, hd_we, hd_data,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/hd_dma_controller.sv
// Block DMA between the HardDisk (registered read) and main memory (combinational read).
// Load costs 2 cycles/word, store 1 cycle/word; range-checked once per request in CHECK.
module hd_dma_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int HD_ADDR_WIDTH  = 13,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int TRACK_WIDTH    = 4,
  parameter int SECTOR_WIDTH   = 10,
  parameter int LEN_WIDTH      = 10,
  parameter int TRACK_SIZE     = 1000
) (
  input logic                 clock,
  input logic                 reset,
  hd_dma_controller_if.master bus
);
  localparam int EW = HD_ADDR_WIDTH + LEN_WIDTH + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] HD_RD  = 3'd2;
  localparam logic [2:0] MEM_WR = 3'd3;
  localparam logic [2:0] MEM_RD = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]                state;
  logic                      dir_q;
  logic [TRACK_WIDTH-1:0]    track_q;
  logic [SECTOR_WIDTH-1:0]   sector_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_base_q;
  logic [LEN_WIDTH-1:0]      length_q;
  logic [HD_ADDR_WIDTH-1:0]  base_q;
  logic [LEN_WIDTH-1:0]      idx;
  logic                      error_q;

  logic [EW-1:0]             base_full;
  logic [EW-1:0]             hd_end;
  logic [EW-1:0]             mem_end;
  logic                      range_bad;
  logic [LEN_WIDTH:0]        idx_next;
  logic [HD_ADDR_WIDTH-1:0]  hd_addr_cur;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_cur;

  // Full-width arithmetic so an out-of-range request can never alias a legal one.
  assign base_full = EW'(sector_q) + EW'(track_q) * EW'(TRACK_SIZE);
  assign hd_end    = base_full + EW'(length_q);
  assign mem_end   = EW'(mem_base_q) + EW'(length_q);
  assign range_bad = (hd_end > (EW'(1) << HD_ADDR_WIDTH)) ||
                     (mem_end > (EW'(1) << MEM_ADDR_WIDTH));

  assign idx_next     = {1'b0, idx} + (LEN_WIDTH+1)'(1);
  assign hd_addr_cur  = base_q + HD_ADDR_WIDTH'(idx);
  assign mem_addr_cur = mem_base_q + MEM_ADDR_WIDTH'(idx);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      track_q    <= '0;
      sector_q   <= '0;
      mem_base_q <= '0;
      length_q   <= '0;
      base_q     <= '0;
      idx        <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dir_q      <= bus.dir;
            track_q    <= bus.track;
            sector_q   <= bus.sector;
            mem_base_q <= bus.mem_base;
            length_q   <= bus.length;
            idx        <= '0;
            error_q    <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          base_q <= base_full[HD_ADDR_WIDTH-1:0];
          if (range_bad) begin
            error_q <= 1'b1;
            state   <= DONE;
          end else if (length_q == '0) begin
            state <= DONE;
          end else begin
            state <= dir_q ? MEM_RD : HD_RD;
          end
        end
        HD_RD: state <= MEM_WR;
        MEM_WR, MEM_RD: begin
          idx <= idx_next[LEN_WIDTH-1:0];
          if (idx_next == {1'b0, length_q})
            state <= DONE;
          else if (state == MEM_WR)
            state <= HD_RD;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data paths are combinational: hd_q lands one cycle after HD_RD, mem_rdata same cycle.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.error     = error_q;
    bus.hd_addr_r = '0;
    bus.hd_addr_w = '0;
    bus.hd_we     = 1'b0;
    bus.hd_data   = DATA_WIDTH'(0);
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = DATA_WIDTH'(0);
    case (state)
      HD_RD: bus.hd_addr_r = hd_addr_cur;
      MEM_WR: begin
        bus.mem_addr  = mem_addr_cur;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bus.hd_q;
      end
      MEM_RD: begin
        bus.mem_addr  = mem_addr_cur;
        bus.hd_addr_w = hd_addr_cur;
        bus.hd_we     = 1'b1;
        bus.hd_data   = bus.mem_rdata;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_hd_dma_controller.sv
// Bench for hd_dma_controller: disk/memory device models plus an array-copy reference model.
module tb_hd_dma_controller;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hd_dma_controller_if bus ();
  hd_dma_controller dut (.clock(clock), .reset(reset), .bus(bus));

  logic [31:0] disk_mem [8192];
  logic [31:0] main_mem [1024];
  logic [31:0] exp_disk [8192];
  logic [31:0] exp_mem  [1024];
  logic [31:0] hd_q_r;
  logic        init_done = 1'b0;
  int hd_we_cnt = 0, mem_we_cnt = 0, viol_cnt = 0;
  int total = 0, bad = 0;

  assign bus.hd_q      = hd_q_r;
  assign bus.mem_rdata = main_mem[bus.mem_addr];

  // Device models: disk has a registered read port, memory a combinational one.
  always @(posedge clock) begin
    if (!init_done) begin
      for (int i = 0; i < 8192; i++) disk_mem[i] <= $urandom;
      for (int i = 0; i < 1024; i++) main_mem[i] <= $urandom;
      init_done <= 1'b1;
    end else begin
      if (bus.hd_we) begin
        disk_mem[bus.hd_addr_w] <= bus.hd_data;
        hd_we_cnt <= hd_we_cnt + 1;
      end
      if (bus.mem_we) begin
        main_mem[bus.mem_addr] <= bus.mem_wdata;
        mem_we_cnt <= mem_we_cnt + 1;
      end
      if ((bus.hd_we || bus.mem_we) && (!bus.busy || bus.done || (bus.hd_we && bus.mem_we)))
        viol_cnt <= viol_cnt + 1;
    end
    hd_q_r <= disk_mem[bus.hd_addr_r];
  end

  // Reference model: whole-request semantics on plain arrays.
  task automatic model_xfer(input int d, input int t, input int s, input int mb, input int len,
                            output int e_err, output int e_lat, output int e_hdw, output int e_mw);
    int base;
    base = s + t * 1000;
    e_err = 0; e_hdw = 0; e_mw = 0;
    if (base + len > 8192 || mb + len > 1024) begin
      e_err = 1; e_lat = 2;
    end else if (len == 0) begin
      e_lat = 2;
    end else begin
      for (int k = 0; k < len; k++) begin
        if (d == 0) exp_mem[mb + k] = exp_disk[base + k];
        else        exp_disk[base + k] = exp_mem[mb + k];
      end
      if (d == 0) begin e_lat = 2 + 2 * len; e_mw = len; end
      else        begin e_lat = 2 + len;     e_hdw = len; end
    end
  endtask

  function automatic int count_diffs();
    int n = 0;
    for (int i = 0; i < 8192; i++) if (disk_mem[i] !== exp_disk[i]) n++;
    for (int i = 0; i < 1024; i++) if (main_mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Issues one request and watches it; glitch_at re-asserts start mid-transfer, abort_at asserts reset.
  task automatic do_xfer(input int d, input int t, input int s, input int mb, input int len,
                         input int glitch_at, input int abort_at,
                         output int lat, output logic err_done, output logic done_seen,
                         output logic busy1, output logic err1,
                         output logic busy_after, output logic done_after, output logic err_after);
    int cyc;
    lat = -1; err_done = 1'bx; done_seen = 1'b0; busy1 = 1'bx; err1 = 1'bx;
    busy_after = 1'bx; done_after = 1'bx; err_after = 1'bx;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.dir = d[0]; bus.track = 4'(t); bus.sector = 10'(s);
    bus.mem_base = 10'(mb); bus.length = 10'(len);
    cyc = 0;
    while (!done_seen && cyc < 3000) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == 1) begin busy1 = bus.busy; err1 = bus.error; bus.start = 1'b0; end
      if (cyc == abort_at) begin reset = 1'b1; break; end
      if (cyc == glitch_at) begin
        bus.start = 1'b1; bus.dir = ~d[0]; bus.track = 4'd0; bus.sector = 10'd3;
        bus.mem_base = 10'd7; bus.length = 10'd5;
      end
      if (cyc == glitch_at + 2) bus.start = 1'b0;
      if (bus.done) begin done_seen = 1'b1; lat = cyc; err_done = bus.error; end
    end
    if (done_seen) begin
      @(posedge clock); #1;
      busy_after = bus.busy; done_after = bus.done; err_after = bus.error;
    end
  endtask

  task automatic test_reset();
    total++;
    if ({bus.busy, bus.done, bus.error} !== 3'b000) begin
      bad++; $display("FAIL reset_status: got %b want 000", {bus.busy, bus.done, bus.error});
    end
    total++;
    if ({bus.hd_we, bus.mem_we} !== 2'b00) begin
      bad++; $display("FAIL reset_we: got %b want 00", {bus.hd_we, bus.mem_we});
    end
    total++;
    if ({bus.hd_addr_r, bus.hd_addr_w, bus.mem_addr} !== 36'd0) begin
      bad++; $display("FAIL reset_addr: got %h want 0", {bus.hd_addr_r, bus.hd_addr_w, bus.mem_addr});
    end
    total++;
    if ({bus.hd_data, bus.mem_wdata} !== 64'd0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {bus.hd_data, bus.mem_wdata});
    end
  endtask

  task automatic test_reset_abort();
    int lat, e_err, e_lat, e_hdw, e_mw;
    logic ed, ds, b1, e1, ba, da, ea;
    for (int k = 0; k < 4; k++) exp_mem[k] = exp_disk[k];
    do_xfer(0, 0, 0, 0, 38, 100000, 10, lat, ed, ds, b1, e1, ba, da, ea);
    total++;
    if (ds !== 1'b0) begin bad++; $display("FAIL abort_no_done: got done_seen=%b want 0", ds); end
    @(posedge clock); #1;
    total++;
    if ({bus.busy, bus.done, bus.error, bus.hd_we, bus.mem_we, bus.hd_addr_r, bus.mem_addr} !== '0) begin
      bad++; $display("FAIL abort_outputs: got busy=%b done=%b we=%b%b want all 0",
                      bus.busy, bus.done, bus.hd_we, bus.mem_we);
    end
    total++;
    if (count_diffs() != 0) begin bad++; $display("FAIL abort_contents: got %0d diffs want 0", count_diffs()); end
    reset = 1'b0;
    model_xfer(1, 2, 0, 500, 3, e_err, e_lat, e_hdw, e_mw);
    do_xfer(1, 2, 0, 500, 3, 100000, 100000, lat, ed, ds, b1, e1, ba, da, ea);
    total++;
    if (lat != e_lat) begin bad++; $display("FAIL abort_restart_latency: got %0d want %0d", lat, e_lat); end
    total++;
    if (count_diffs() != 0) begin bad++; $display("FAIL abort_restart_contents: got %0d diffs want 0", count_diffs()); end
  endtask

  task automatic test_load();
    int lat, e_err, e_lat, e_hdw, e_mw, mw0, hw0;
    logic ed, ds, b1, e1, ba, da, ea;
    mw0 = mem_we_cnt; hw0 = hd_we_cnt;
    model_xfer(0, 0, 0, 0, 38, e_err, e_lat, e_hdw, e_mw);
    do_xfer(0, 0, 0, 0, 38, 100000, 100000, lat, ed, ds, b1, e1, ba, da, ea);
    total++;
    if (lat != 78) begin bad++; $display("FAIL load_latency: got %0d want 78", lat); end
    total++;
    if (ed !== 1'b0 || b1 !== 1'b1) begin bad++; $display("FAIL load_flags: got error=%b busy=%b want 0 1", ed, b1); end
    total++;
    if (ba !== 1'b0 || da !== 1'b0) begin bad++; $display("FAIL load_after: got busy=%b done=%b want 0 0", ba, da); end
    total++;
    if (mem_we_cnt - mw0 != 38 || hd_we_cnt != hw0) begin
      bad++; $display("FAIL load_strobes: got mem_we=%0d hd_we=%0d want 38 0", mem_we_cnt - mw0, hd_we_cnt - hw0);
    end
    total++;
    if (count_diffs() != 0) begin bad++; $display("FAIL load_contents: got %0d diffs want 0", count_diffs()); end
  endtask

  task automatic test_store();
    int lat, e_err, e_lat, e_hdw, e_mw, hw0;
    logic ed, ds, b1, e1, ba, da, ea;
    hw0 = hd_we_cnt;
    model_xfer(1, 1, 5, 100, 4, e_err, e_lat, e_hdw, e_mw);
    do_xfer(1, 1, 5, 100, 4, 100000, 100000, lat, ed, ds, b1, e1, ba, da, ea);
    total++;
    if (lat != 6) begin bad++; $display("FAIL store_latency: got %0d want 6", lat); end
    total++;
    if (hd_we_cnt - hw0 != 4) begin bad++; $display("FAIL store_strobes: got %0d want 4", hd_we_cnt - hw0); end
    total++;
    if (count_diffs() != 0) begin bad++; $display("FAIL store_contents: got %0d diffs want 0", count_diffs()); end
  endtask

  task automatic test_range();
    int lat, e_err, e_lat, e_hdw, e_mw, mw0, hw0;
    logic ed, ds, b1, e1, ba, da, ea;
    mw0 = mem_we_cnt; hw0 = hd_we_cnt;
    model_xfer(0, 8, 192, 0, 1, e_err, e_lat, e_hdw, e_mw);
    do_xfer(0, 8, 192, 0, 1, 100000, 100000, lat, ed, ds, b1, e1, ba, da, ea);
    total++;
    if (ed !== 1'b1 || lat != 2) begin bad++; $display("FAIL range_error: got error=%b lat=%0d want 1 2", ed, lat); end
    total++;
    if (ea !== 1'b1) begin bad++; $display("FAIL range_sticky: got %b want 1", ea); end
    total++;
    if (mem_we_cnt != mw0 || hd_we_cnt != hw0) begin
      bad++; $display("FAIL range_no_write: got %0d writes want 0", mem_we_cnt - mw0 + hd_we_cnt - hw0);
    end
    model_xfer(0, 8, 191, 0, 1, e_err, e_lat, e_hdw, e_mw);
    do_xfer(0, 8, 191, 0, 1, 100000, 100000, lat, ed, ds, b1, e1, ba, da, ea);
    total++;
    if (e1 !== 1'b0 || ed !== 1'b0) begin bad++; $display("FAIL range_clear: got %b%b want 00", e1, ed); end
    total++;
    if (lat != 4 || mem_we_cnt - mw0 != 1) begin
      bad++; $display("FAIL range_last_word: got lat=%0d writes=%0d want 4 1", lat, mem_we_cnt - mw0);
    end
    total++;
    if (count_diffs() != 0) begin bad++; $display("FAIL range_contents: got %0d diffs want 0", count_diffs()); end
  endtask

  task automatic test_zero_length();
    int lat, e_err, e_lat, e_hdw, e_mw, w0;
    logic ed, ds, b1, e1, ba, da, ea;
    w0 = mem_we_cnt + hd_we_cnt;
    model_xfer(1, 3, 7, 20, 0, e_err, e_lat, e_hdw, e_mw);
    do_xfer(1, 3, 7, 20, 0, 100000, 100000, lat, ed, ds, b1, e1, ba, da, ea);
    total++;
    if (lat != 2 || ed !== 1'b0) begin bad++; $display("FAIL zero_len: got lat=%0d error=%b want 2 0", lat, ed); end
    total++;
    if (mem_we_cnt + hd_we_cnt != w0) begin bad++; $display("FAIL zero_no_write: got %0d want 0", mem_we_cnt + hd_we_cnt - w0); end
  endtask

  task automatic test_start_while_busy();
    int lat, e_err, e_lat, e_hdw, e_mw, mw0, hw0;
    logic ed, ds, b1, e1, ba, da, ea;
    mw0 = mem_we_cnt; hw0 = hd_we_cnt;
    model_xfer(0, 2, 10, 200, 20, e_err, e_lat, e_hdw, e_mw);
    do_xfer(0, 2, 10, 200, 20, 5, 100000, lat, ed, ds, b1, e1, ba, da, ea);
    total++;
    if (lat != 42) begin bad++; $display("FAIL busy_start_latency: got %0d want 42", lat); end
    total++;
    if (mem_we_cnt - mw0 != 20 || hd_we_cnt != hw0 || ba !== 1'b0) begin
      bad++; $display("FAIL busy_start_strobes: got mem_we=%0d hd_we=%0d busy=%b want 20 0 0",
                      mem_we_cnt - mw0, hd_we_cnt - hw0, ba);
    end
    total++;
    if (count_diffs() != 0) begin bad++; $display("FAIL busy_start_contents: got %0d diffs want 0", count_diffs()); end
  endtask

  task automatic test_random();
    int lat, e_err, e_lat, e_hdw, e_mw, mw0, hw0, d, t, s, mb, len;
    logic ed, ds, b1, e1, ba, da, ea;
    for (int it = 0; it < 24; it++) begin
      d = int'($urandom_range(0, 1)); t = int'($urandom_range(0, 9));
      s = int'($urandom_range(0, 1023)); mb = int'($urandom_range(0, 1023));
      len = int'($urandom_range(0, 40));
      mw0 = mem_we_cnt; hw0 = hd_we_cnt;
      model_xfer(d, t, s, mb, len, e_err, e_lat, e_hdw, e_mw);
      do_xfer(d, t, s, mb, len, 100000, 100000, lat, ed, ds, b1, e1, ba, da, ea);
      total++;
      if (lat != e_lat || ed !== e_err[0] || da !== 1'b0) begin
        bad++; $display("FAIL rand%0d_status: got lat=%0d err=%b want %0d %0d", it, lat, ed, e_lat, e_err);
      end
      total++;
      if (mem_we_cnt - mw0 != e_mw || hd_we_cnt - hw0 != e_hdw) begin
        bad++; $display("FAIL rand%0d_strobes: got %0d/%0d want %0d/%0d", it,
                        mem_we_cnt - mw0, hd_we_cnt - hw0, e_mw, e_hdw);
      end
      total++;
      if (count_diffs() != 0) begin bad++; $display("FAIL rand%0d_contents: got %0d diffs want 0", it, count_diffs()); end
    end
    total++;
    if (viol_cnt != 0) begin bad++; $display("FAIL we_exclusive: got %0d bad strobe cycles want 0", viol_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.dir = 1'b0; bus.track = '0; bus.sector = '0;
    bus.mem_base = '0; bus.length = '0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    for (int i = 0; i < 8192; i++) exp_disk[i] = disk_mem[i];
    for (int i = 0; i < 1024; i++) exp_mem[i] = main_mem[i];
    reset = 1'b0;
    test_reset_abort();
    test_load();
    test_store();
    test_range();
    test_zero_length();
    test_start_while_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
